refclk_gen: RTL and testbench

- Generates a nominal 32,768 Hz reference clock from the system clock using a phase-accumulator (fractional-N) divider.
- Emits a one-cycle tick on each rising edge of the generated clock.
- Sits on the output side of the timekeeping path: it drives the reference-clock pin or line that the receive-side reference-clock synchronizer samples.
- The increment is loadable, and it can be trimmed ±1 LSB at run time for frequency calibration.

---
 rtl/refclk_gen.sv | 69 ++++++
 tb/tb_refclk_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/refclk_gen.sv
// Fractional-N reference clock generator: a phase accumulator whose MSB is the
// output clock, with a loadable, trimmable increment and a rising-edge tick.
module refclk_gen #(
    parameter int unsigned          ACC_WIDTH   = 24,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = 24'd54976
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic                 i_sync_clr,
    input  logic                 i_inc_load,
    input  logic [ACC_WIDTH-1:0] i_inc,
    input  logic                 i_trim_up,
    input  logic                 i_trim_dn,
    output logic                 o_refclk,
    output logic                 o_tick,
    output logic [ACC_WIDTH-1:0] o_inc
);

    localparam logic [ACC_WIDTH-1:0] INC_ONE = ACC_WIDTH'(1);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_inc;
    logic                 r_tick;

    logic [ACC_WIDTH-1:0] w_acc_sum;
    logic [ACC_WIDTH-1:0] w_inc_up;
    logic [ACC_WIDTH-1:0] w_inc_dn;
    logic                 w_rise;

    // Carry out of the sum is deliberately dropped: the wrap is the divider.
    assign w_acc_sum = r_acc + r_inc;
    assign w_rise    = ~r_acc[ACC_WIDTH-1] & w_acc_sum[ACC_WIDTH-1];

    // Trim saturates at full scale going up and at 1 going down, never 0.
    assign w_inc_up = (r_inc == '1)     ? r_inc   : r_inc + INC_ONE;
    assign w_inc_dn = (r_inc <= INC_ONE) ? INC_ONE : r_inc - INC_ONE;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_acc  <= '0;
            r_inc  <= DEFAULT_INC;
            r_tick <= 1'b0;
        end else begin
            if (i_sync_clr) begin
                r_acc  <= '0;
                r_tick <= 1'b0;
            end else if (i_en) begin
                r_acc  <= w_acc_sum;
                r_tick <= w_rise;
            end else begin
                r_tick <= 1'b0;
            end

            if (i_inc_load) begin
                r_inc <= i_inc;
            end else if (i_trim_up && !i_trim_dn) begin
                r_inc <= w_inc_up;
            end else if (i_trim_dn && !i_trim_up) begin
                r_inc <= w_inc_dn;
            end
        end
    end

    assign o_refclk = r_acc[ACC_WIDTH-1];
    assign o_tick   = r_tick;
    assign o_inc    = r_inc;

endmodule

// File: tb/tb_refclk_gen.sv
// Self-checking bench for refclk_gen: a cycle model pushes expected outputs per
// edge into a scoreboard that a monitor pops after each rising edge.
module tb_refclk_gen;

    localparam logic [23:0] DEF_INC = 24'd54976;

    logic        clk = 1'b0;
    logic        rst_n, en, clr, load, up, dn;
    logic [23:0] inc_in;
    logic        refclk, tick;
    logic [23:0] inc_out;

    refclk_gen #(.ACC_WIDTH(24), .DEFAULT_INC(24'd54976)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_sync_clr(clr),
        .i_inc_load(load), .i_inc(inc_in), .i_trim_up(up), .i_trim_dn(dn),
        .o_refclk(refclk), .o_tick(tick), .o_inc(inc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        refclk;
        logic        tick;
        logic [23:0] inc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    logic [23:0] m_acc, m_inc;
    logic        m_tick;

    int cyc = 0, tick_cnt = 0, last_tick = -1, hi_len = 0;
    int min_per, max_per, n_per, min_hi, max_hi, n_hi;

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (refclk !== e.refclk) begin
                errors++;
                $display("FAIL sb_refclk cyc=%0d got=%b exp=%b", cyc, refclk, e.refclk);
            end
            checks++;
            if (tick !== e.tick) begin
                errors++;
                $display("FAIL sb_tick cyc=%0d got=%b exp=%b", cyc, tick, e.tick);
            end
            checks++;
            if (inc_out !== e.inc) begin
                errors++;
                $display("FAIL sb_inc cyc=%0d got=%h exp=%h", cyc, inc_out, e.inc);
            end
        end
        cyc++;
        if (tick === 1'b1) begin
            tick_cnt++;
            if (last_tick >= 0) begin
                n_per++;
                if (cyc - last_tick < min_per) min_per = cyc - last_tick;
                if (cyc - last_tick > max_per) max_per = cyc - last_tick;
            end
            last_tick = cyc;
        end
        if (refclk === 1'b1) begin
            hi_len++;
        end else if (hi_len > 0) begin
            n_hi++;
            if (hi_len < min_hi) min_hi = hi_len;
            if (hi_len > max_hi) max_hi = hi_len;
            hi_len = 0;
        end
    end

    task automatic clear_stats();
        last_tick = -1; hi_len = 0;
        min_per = 1 << 30; max_per = 0; n_per = 0;
        min_hi  = 1 << 30; max_hi  = 0; n_hi  = 0;
    endtask

    // One clock edge: drive inputs at the falling edge, predict, then wait past
    // the rising edge so callers see the updated outputs.
    task automatic step(input logic r, input logic e_i, input logic c,
                        input logic l, input logic [23:0] v,
                        input logic u, input logic d);
        logic [24:0] sum;
        logic [23:0] n_inc;
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e_i; clr = c; load = l; inc_in = v; up = u; dn = d;
        if (!r) begin
            m_acc = 24'h0; m_inc = DEF_INC; m_tick = 1'b0;
        end else begin
            n_inc = m_inc;
            if (l) n_inc = v;
            else if (u && !d) n_inc = (m_inc == 24'hFFFFFF) ? m_inc : m_inc + 24'd1;
            else if (d && !u) n_inc = (m_inc < 24'd2) ? 24'd1 : m_inc - 24'd1;
            if (c) begin
                m_acc = 24'h0; m_tick = 1'b0;
            end else if (e_i) begin
                sum = {1'b0, m_acc} + {1'b0, m_inc};
                m_tick = (m_acc < 24'h800000) && (sum[23:0] >= 24'h800000);
                m_acc = sum[23:0];
            end else begin
                m_tick = 1'b0;
            end
            m_inc = n_inc;
        end
        x.refclk = m_acc[23]; x.tick = m_tick; x.inc = m_inc;
        sb.push_back(x);
        #7;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 24'h0, 0, 0);
        step(0, 0, 0, 0, 24'h0, 0, 0);
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 24'h0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (refclk !== 1'b0 || tick !== 1'b0 || inc_out !== DEF_INC) begin
            errors++;
            $display("FAIL reset_state got=%b/%b/%h exp=0/0/%h", refclk, tick, inc_out, DEF_INC);
        end
    endtask

    task automatic test_default_rate();
        int t0;
        do_reset();
        clear_stats();
        t0 = tick_cnt;
        run_en(10000);
        checks++;
        if (tick_cnt - t0 < 32 || tick_cnt - t0 > 33) begin
            errors++;
            $display("FAIL default_ticks got=%0d exp=32..33", tick_cnt - t0);
        end
        checks++;
        if (n_per < 30 || min_per < 305 || max_per > 306) begin
            errors++;
            $display("FAIL default_period got=%0d..%0d (n=%0d) exp=305..306", min_per, max_per, n_per);
        end
        checks++;
        if (n_hi < 30 || min_hi < 152 || max_hi > 153) begin
            errors++;
            $display("FAIL default_high got=%0d..%0d (n=%0d) exp=152..153", min_hi, max_hi, n_hi);
        end
    endtask

    task automatic test_quarter_rate();
        int t0;
        logic [3:0] pat;
        do_reset();
        step(1, 0, 0, 1, 24'h400000, 0, 0);
        t0 = tick_cnt;
        pat = 4'b0;
        for (int i = 0; i < 100; i++) begin
            step(1, 1, 0, 0, 24'h0, 0, 0);
            if (i < 4) pat[3 - i] = refclk;
        end
        checks++;
        if (pat !== 4'b0110) begin
            errors++;
            $display("FAIL quarter_pattern got=%b exp=0110", pat);
        end
        checks++;
        if (tick_cnt - t0 != 25) begin
            errors++;
            $display("FAIL quarter_ticks got=%0d exp=25", tick_cnt - t0);
        end
    endtask

    task automatic test_trim();
        do_reset();
        step(1, 0, 0, 1, 24'd1, 0, 0);
        step(1, 0, 0, 0, 24'h0, 0, 1);
        checks++;
        if (inc_out !== 24'd1) begin
            errors++; $display("FAIL trim_dn_sat got=%h exp=000001", inc_out);
        end
        step(1, 0, 0, 1, 24'hFFFFFF, 0, 0);
        step(1, 0, 0, 0, 24'h0, 1, 0);
        checks++;
        if (inc_out !== 24'hFFFFFF) begin
            errors++; $display("FAIL trim_up_sat got=%h exp=FFFFFF", inc_out);
        end
        step(1, 0, 0, 1, 24'h000100, 0, 0);
        step(1, 0, 0, 0, 24'h0, 1, 1);
        checks++;
        if (inc_out !== 24'h000100) begin
            errors++; $display("FAIL trim_both got=%h exp=000100", inc_out);
        end
        step(1, 0, 0, 1, 24'd5, 1, 0);
        checks++;
        if (inc_out !== 24'd5) begin
            errors++; $display("FAIL load_over_trim got=%h exp=000005", inc_out);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 1, 24'h000100, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 24'h0, 1, 0);
        step(1, 0, 0, 0, 24'h0, 0, 1);
        checks++;
        if (inc_out !== 24'h000102) begin
            errors++; $display("FAIL trim_seq got=%h exp=000102", inc_out);
        end
    endtask

    task automatic test_enable_gate();
        int t0, wait_n;
        do_reset();
        step(1, 0, 0, 1, 24'h400000, 0, 0);
        run_en(3);
        t0 = tick_cnt;
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 24'h0, 0, 0);
        checks++;
        if (refclk !== 1'b1 || tick_cnt != t0) begin
            errors++;
            $display("FAIL en_hold got=refclk %b ticks %0d exp=refclk 1 ticks 0", refclk, tick_cnt - t0);
        end
        // Held at 0xC00000: three increments remain to the next rising edge.
        wait_n = 0;
        for (int i = 0; i < 8 && tick_cnt == t0; i++) begin
            step(1, 1, 0, 0, 24'h0, 0, 0);
            wait_n++;
        end
        checks++;
        if (wait_n != 3) begin
            errors++; $display("FAIL en_resume got=%0d cycles exp=3", wait_n);
        end
    endtask

    task automatic test_sync_clr();
        logic t1;
        do_reset();
        step(1, 0, 0, 1, 24'h400000, 0, 0);
        run_en(2);
        step(1, 1, 1, 0, 24'h0, 0, 0);
        checks++;
        if (refclk !== 1'b0 || tick !== 1'b0) begin
            errors++; $display("FAIL clr_force got=%b/%b exp=0/0", refclk, tick);
        end
        step(1, 1, 0, 0, 24'h0, 0, 0);
        t1 = tick;
        step(1, 1, 0, 0, 24'h0, 0, 0);
        checks++;
        if (t1 !== 1'b0 || tick !== 1'b1) begin
            errors++; $display("FAIL clr_first_tick got=%b%b exp=01", t1, tick);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 1, 24'h123456, 0, 0);
        run_en(20);
        step(0, 1, 0, 0, 24'h0, 0, 0);
        checks++;
        if (refclk !== 1'b0 || tick !== 1'b0 || inc_out !== 24'd54976) begin
            errors++;
            $display("FAIL reset_mid got=%b/%b/%h exp=0/0/00d6c0", refclk, tick, inc_out);
        end
        run_en(200);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        up = 1'b0; dn = 1'b0; inc_in = 24'h0;
        clear_stats();
        test_reset();
        test_default_rate();
        test_quarter_rate();
        test_trim();
        test_back_to_back();
        test_enable_gate();
        test_sync_clr();
        test_reset_mid();
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
